// File: rtl/data_cache_wb.sv
// Direct-mapped write-back/write-allocate data cache with byte/half/word access and flush.
// Define DCACHE_STATS_EN to add hit/miss/write-back counters.
module data_cache_wb #(
    parameter int unsigned NUM_SETS  = 4,
    parameter int unsigned LINE_BITS = 128,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         flush,
    input  logic                                         mem_read,
    input  logic                                         mem_write,
    input  logic [1:0]                                   access_size,
    input  logic [ADDR_W-1:0]                            address,
    input  logic [31:0]                                  writedata,
    output logic [31:0]                                  readdata,
    output logic                                         stall,
    output logic                                         flush_done,
`ifdef DCACHE_STATS_EN
    output logic [31:0]                                  hit_count,
    output logic [31:0]                                  miss_count,
    output logic [31:0]                                  wb_count,
`endif
    output logic                                         reqD_mem,
    output logic [ADDR_W-$clog2(LINE_BITS/8)-1:0]        reqAddrD_mem,
    input  logic [LINE_BITS-1:0]                         data_from_mem,
    input  logic                                         read_ready_from_mem,
    output logic                                         reqD_cache_write,
    output logic [ADDR_W-$clog2(LINE_BITS/8)-1:0]        reqAddrD_write_mem,
    output logic [LINE_BITS-1:0]                         data_to_mem,
    input  logic                                         written_data_ack
);
    localparam int unsigned INDEX_W  = $clog2(NUM_SETS);
    localparam int unsigned OFFSET_W = $clog2(LINE_BITS / 8);
    localparam int unsigned LADDR_W  = ADDR_W - OFFSET_W;
    localparam int unsigned TAG_W    = LADDR_W - INDEX_W;

    typedef enum logic [2:0] {StIdle, StWriteback, StRefill, StFlushScan, StFlushWb} state_e;

    state_e               state_q, state_d;
    logic [LINE_BITS-1:0] data_q [NUM_SETS];
    logic [TAG_W-1:0]     tag_q  [NUM_SETS];
    logic [NUM_SETS-1:0]  valid_q, valid_d, dirty_q, dirty_d;
    logic                 pending_q, pending_d, done_q, done_d, retry_q, retry_d;
    logic [INDEX_W-1:0]   scan_q, scan_d;
    logic                 req_mem_q, req_mem_d, req_wr_q, req_wr_d;
    logic [LADDR_W-1:0]   raddr_q, raddr_d, waddr_q, waddr_d;
    logic [LINE_BITS-1:0] wdata_q, wdata_d;

    logic [OFFSET_W-1:0]  offset, offset_al;
    logic [INDEX_W-1:0]   index, miss_idx, data_widx;
    logic [TAG_W-1:0]     tag, tag_wval;
    logic [31:0]          size_mask, rd_word;
    logic [LINE_BITS-1:0] line_rd, wmask_line, wdata_line, merged, data_wval;
    logic                 hit, req, idle_ok, data_we, tag_we, flush_end;

    assign offset   = address[OFFSET_W-1:0];
    assign index    = address[OFFSET_W +: INDEX_W];
    assign tag      = address[ADDR_W-1 -: TAG_W];
    assign miss_idx = raddr_q[INDEX_W-1:0];

    always_comb begin
        offset_al = offset;
        size_mask = 32'hFFFF_FFFF;
        case (access_size)
            2'b00: size_mask = 32'h0000_00FF;
            2'b01: begin
                size_mask = 32'h0000_FFFF;
                offset_al = {offset[OFFSET_W-1:1], 1'b0};
            end
            default: offset_al = {offset[OFFSET_W-1:2], 2'b00};
        endcase
    end

    assign line_rd    = data_q[index];
    assign rd_word    = 32'(line_rd >> {offset_al, 3'b000}) & size_mask;
    assign wmask_line = LINE_BITS'(size_mask) << {offset_al, 3'b000};
    assign wdata_line = LINE_BITS'(writedata & size_mask) << {offset_al, 3'b000};
    assign merged     = (line_rd & ~wmask_line) | (wdata_line & wmask_line);

    assign hit      = valid_q[index] && (tag_q[index] == tag);
    assign req      = mem_read | mem_write;
    assign idle_ok  = (state_q == StIdle) && !pending_q;
    assign stall    = req && !(idle_ok && hit);
    assign readdata = (idle_ok && hit && mem_read && !mem_write) ? rd_word : 32'd0;

    assign flush_done         = done_q;
    assign reqD_mem           = req_mem_q;
    assign reqAddrD_mem       = raddr_q;
    assign reqD_cache_write   = req_wr_q;
    assign reqAddrD_write_mem = waddr_q;
    assign data_to_mem        = wdata_q;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q | flush;
        scan_d    = scan_q;
        valid_d   = valid_q;
        dirty_d   = dirty_q;
        req_mem_d = req_mem_q;
        req_wr_d  = req_wr_q;
        raddr_d   = raddr_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        done_d    = 1'b0;
        retry_d   = 1'b0;
        data_we   = 1'b0;
        tag_we    = 1'b0;
        data_widx = index;
        data_wval = merged;
        tag_wval  = tag;
        flush_end = 1'b0;
        case (state_q)
            StIdle: begin
                if (pending_q) begin
                    state_d   = StFlushScan;
                    pending_d = flush;
                    scan_d    = '0;
                end else if (req) begin
                    if (hit) begin
                        if (mem_write) begin
                            data_we        = 1'b1;
                            dirty_d[index] = 1'b1;
                        end
                    end else begin
                        raddr_d = {tag, index};
                        if (valid_q[index] && dirty_q[index]) begin
                            state_d  = StWriteback;
                            req_wr_d = 1'b1;
                            waddr_d  = {tag_q[index], index};
                            wdata_d  = data_q[index];
                        end else begin
                            state_d   = StRefill;
                            req_mem_d = 1'b1;
                        end
                    end
                end
            end
            StWriteback: begin
                if (written_data_ack) begin
                    req_wr_d          = 1'b0;
                    dirty_d[miss_idx] = 1'b0;
                    req_mem_d         = 1'b1;
                    state_d           = StRefill;
                end
            end
            StRefill: begin
                if (read_ready_from_mem) begin
                    req_mem_d         = 1'b0;
                    data_we           = 1'b1;
                    tag_we            = 1'b1;
                    data_widx         = miss_idx;
                    data_wval         = data_from_mem;
                    tag_wval          = raddr_q[LADDR_W-1 -: TAG_W];
                    valid_d[miss_idx] = 1'b1;
                    dirty_d[miss_idx] = 1'b0;
                    retry_d           = 1'b1;
                    state_d           = StIdle;
                end
            end
            StFlushScan: begin
                if (valid_q[scan_q] && dirty_q[scan_q]) begin
                    req_wr_d = 1'b1;
                    waddr_d  = {tag_q[scan_q], scan_q};
                    wdata_d  = data_q[scan_q];
                    state_d  = StFlushWb;
                end else if (scan_q == INDEX_W'(NUM_SETS - 1)) begin
                    flush_end = 1'b1;
                end else begin
                    scan_d = scan_q + INDEX_W'(1);
                end
            end
            StFlushWb: begin
                if (written_data_ack) begin
                    req_wr_d        = 1'b0;
                    dirty_d[scan_q] = 1'b0;
                    if (scan_q == INDEX_W'(NUM_SETS - 1)) begin
                        flush_end = 1'b1;
                    end else begin
                        scan_d  = scan_q + INDEX_W'(1);
                        state_d = StFlushScan;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (flush_end) begin
            valid_d = '0;
            dirty_d = '0;
            done_d  = 1'b1;
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            valid_q   <= '0;
            dirty_q   <= '0;
            pending_q <= 1'b0;
            done_q    <= 1'b0;
            retry_q   <= 1'b0;
            scan_q    <= '0;
            req_mem_q <= 1'b0;
            req_wr_q  <= 1'b0;
            raddr_q   <= '0;
            waddr_q   <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            dirty_q   <= dirty_d;
            pending_q <= pending_d;
            done_q    <= done_d;
            retry_q   <= retry_d;
            scan_q    <= scan_d;
            req_mem_q <= req_mem_d;
            req_wr_q  <= req_wr_d;
            raddr_q   <= raddr_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
        end
    end

    // Line storage is qualified by valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (data_we) data_q[data_widx] <= data_wval;
        if (tag_we)  tag_q[data_widx]  <= tag_wval;
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_count  <= 32'd0;
            miss_count <= 32'd0;
            wb_count   <= 32'd0;
        end else begin
            // retry_q marks the replay of a request that just refilled; it is not a fresh hit.
            if (idle_ok && req && hit && !retry_q) hit_count <= hit_count + 32'd1;
            if (idle_ok && req && !hit) miss_count <= miss_count + 32'd1;
            if ((state_q == StWriteback || state_q == StFlushWb) && written_data_ack)
                wb_count <= wb_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_data_cache_wb.sv
// Scoreboard bench for data_cache_wb with a line-wide memory model (refill 3, write-back 2 cycles).
module tb_data_cache_wb;
    localparam int LADDR_W = 28;

    logic               clk, reset, flush, mem_read, mem_write;
    logic [1:0]         access_size;
    logic [31:0]        address, writedata, readdata;
    logic               stall, flush_done, reqD_mem, read_ready_from_mem;
    logic               reqD_cache_write, written_data_ack;
    logic [LADDR_W-1:0] reqAddrD_mem, reqAddrD_write_mem;
    logic [127:0]       data_from_mem, data_to_mem;
`ifdef DCACHE_STATS_EN
    logic [31:0]        hit_count, miss_count, wb_count;
`endif

    data_cache_wb #(.NUM_SETS(4), .LINE_BITS(128), .ADDR_W(32)) dut (
        .clk                (clk),
        .reset              (reset),
        .flush              (flush),
        .mem_read           (mem_read),
        .mem_write          (mem_write),
        .access_size        (access_size),
        .address            (address),
        .writedata          (writedata),
        .readdata           (readdata),
        .stall              (stall),
        .flush_done         (flush_done),
`ifdef DCACHE_STATS_EN
        .hit_count          (hit_count),
        .miss_count         (miss_count),
        .wb_count           (wb_count),
`endif
        .reqD_mem           (reqD_mem),
        .reqAddrD_mem       (reqAddrD_mem),
        .data_from_mem      (data_from_mem),
        .read_ready_from_mem(read_ready_from_mem),
        .reqD_cache_write   (reqD_cache_write),
        .reqAddrD_write_mem (reqAddrD_write_mem),
        .data_to_mem        (data_to_mem),
        .written_data_ack   (written_data_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int wb_seen = 0;
    int done_cycles = 0;
    logic [31:0]        exp_rd[$];
    logic [LADDR_W-1:0] exp_rf[$];
    logic [LADDR_W-1:0] exp_wb[$];
    logic [127:0]       mem [int unsigned];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] line_of(input logic [LADDR_W-1:0] la);
        if (mem.exists(32'(la))) return mem[32'(la)];
        return {4'hF, la, 4'hE, la, 4'hD, la, 4'hC, la};
    endfunction

    // Memory model: ready on the 4th cycle of reqD_mem, ack on the 3rd cycle of a write-back.
    int rd_cnt = 0;
    int wr_cnt = 0;
    always @(posedge clk) begin
        #1;
        rd_cnt = reqD_mem ? rd_cnt + 1 : 0;
        wr_cnt = reqD_cache_write ? wr_cnt + 1 : 0;
        read_ready_from_mem = reqD_mem && (rd_cnt > 3);
        written_data_ack    = reqD_cache_write && (wr_cnt > 2);
        data_from_mem       = line_of(reqAddrD_mem);
    end

    // Monitor: pops the scoreboard whenever the DUT presents a read result or starts a request.
    logic rf_prev = 1'b0;
    logic wb_prev = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            rf_prev = 1'b0;
            wb_prev = 1'b0;
        end else begin
            if (mem_read && !mem_write && !stall) begin
                if (exp_rd.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rd_unexpected: got %0h expected none", readdata);
                end else check("readdata", 128'(readdata), 128'(exp_rd.pop_front()));
            end
            if (reqD_mem && !rf_prev) begin
                if (exp_rf.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rf_unexpected: got %0h expected none", reqAddrD_mem);
                end else check("refill_addr", 128'(reqAddrD_mem), 128'(exp_rf.pop_front()));
            end
            if (reqD_cache_write && !wb_prev) begin
                if (exp_wb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wb_unexpected: got %0h expected none", reqAddrD_write_mem);
                end else check("wb_addr", 128'(reqAddrD_write_mem), 128'(exp_wb.pop_front()));
            end
            rf_prev = reqD_mem;
            wb_prev = reqD_cache_write;
            if (reqD_cache_write && written_data_ack) begin
                mem[32'(reqAddrD_write_mem)] = data_to_mem;
                wb_seen++;
            end
            if (flush_done) done_cycles++;
        end
    end

    task automatic access(input logic rd, input logic wr, input logic [1:0] sz,
                          input logic [31:0] addr, input logic [31:0] wd, output int stalls);
        int n;
        mem_read = rd; mem_write = wr; access_size = sz; address = addr; writedata = wd;
        n = 0;
        @(negedge clk);
        while (stall && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (stall) begin
            checks++; errors++;
            $display("FAIL access_timeout: got stall=1 expected 0 at addr %0h", addr);
        end
        stalls = n;
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n, wb0;
        reset = 1'b1; flush = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        access_size = 2'b10; address = '0; writedata = '0;
        read_ready_from_mem = 1'b0; written_data_ack = 1'b0; data_from_mem = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_reqD_mem", 128'(reqD_mem), 0);
        check("rst_req_write", 128'(reqD_cache_write), 0);
        check("rst_flush_done", 128'(flush_done), 0);
        check("rst_stall", 128'(stall), 0);
        check("rst_data_to_mem", data_to_mem, 0);
        @(posedge clk); #1;
        mem[32'h10] = {64'h0123456789ABCDEF, 64'hDDCCBBAA_44332211};

        // cold read miss
        exp_rf.push_back(28'h10); exp_rd.push_back(32'h44332211);
        access(1, 0, 2'b10, 32'h100, 0, n); check("cold_stall", 128'(n), 5);
        // byte/half stores, sized reads, write priority
        access(0, 1, 2'b00, 32'h101, 32'hEE, n); check("st_byte_stall", 128'(n), 0);
        access(0, 1, 2'b01, 32'h102, 32'hBEEF, n);
        exp_rd.push_back(32'hBEEFEE11);
        access(1, 0, 2'b10, 32'h100, 0, n); check("rd_hit_stall", 128'(n), 0);
        exp_rd.push_back(32'h000000BE); access(1, 0, 2'b00, 32'h103, 0, n);
        exp_rd.push_back(32'h0000BBAA); access(1, 0, 2'b01, 32'h105, 0, n);
        exp_rd.push_back(32'h01234567); access(1, 0, 2'b11, 32'h10E, 0, n);
        access(1, 1, 2'b10, 32'h108, 32'h55667788, n);
        // dirty eviction, then clean re-fetch of the written-back line
        exp_wb.push_back(28'h10); exp_rf.push_back(28'h14); exp_rd.push_back(32'hC0000014);
        access(1, 0, 2'b10, 32'h140, 0, n); check("dirty_miss_stall", 128'(n), 8);
        exp_rf.push_back(28'h10); exp_rd.push_back(32'hBEEFEE11);
        access(1, 0, 2'b10, 32'h100, 0, n); check("clean_evict_stall", 128'(n), 5);
        exp_rd.push_back(32'h55667788); access(1, 0, 2'b10, 32'h108, 0, n);

        // flush with sets 0 and 2 dirty, set 1 clean, set 3 invalid
        access(0, 1, 2'b10, 32'h100, 32'hCAFEF00D, n);
        exp_rf.push_back(28'h12);
        access(0, 1, 2'b10, 32'h124, 32'h12345678, n); check("wr_miss_stall", 128'(n), 5);
        exp_rf.push_back(28'h11); exp_rd.push_back(32'hC0000011);
        access(1, 0, 2'b10, 32'h110, 0, n);
        exp_wb.push_back(28'h10); exp_wb.push_back(28'h12);
        wb0 = wb_seen; done_cycles = 0;
        flush = 1'b1; @(posedge clk); #1 flush = 1'b0;
        n = 0;
        @(negedge clk);
        while (!flush_done && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("flush_done_seen", 128'(flush_done), 1);
        @(negedge clk);
        check("flush_done_pulse", 128'(flush_done), 0);
        check("flush_wb_count", 128'(wb_seen - wb0), 2);
        check("flush_done_cycles", 128'(done_cycles), 1);
        @(posedge clk); #1;
        exp_rf.push_back(28'h10); exp_rd.push_back(32'hCAFEF00D);
        access(1, 0, 2'b10, 32'h100, 0, n); check("post_flush_stall", 128'(n), 5);
        exp_rf.push_back(28'h12); exp_rd.push_back(32'h12345678);
        access(1, 0, 2'b10, 32'h124, 0, n);
        exp_rf.push_back(28'h11); exp_rd.push_back(32'hC0000011);
        access(1, 0, 2'b10, 32'h110, 0, n);
`ifdef DCACHE_STATS_EN
        check("hit_count", 128'(hit_count), 9);
        check("miss_count", 128'(miss_count), 8);
        check("wb_count", 128'(wb_count), 3);
`endif

        // reset in the middle of a refill
        exp_rf.push_back(28'h13);
        mem_read = 1'b1; access_size = 2'b10; address = 32'h130;
        n = 0;
        @(negedge clk);
        while (!reqD_mem && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("midrst_req_seen", 128'(reqD_mem), 1);
        #2 reset = 1'b1;
        #1;
        check("midrst_reqD_mem", 128'(reqD_mem), 0);
        check("midrst_reqAddrD_mem", 128'(reqAddrD_mem), 0);
        check("midrst_req_write", 128'(reqD_cache_write), 0);
        check("midrst_wb_addr", 128'(reqAddrD_write_mem), 0);
        check("midrst_data_to_mem", data_to_mem, 0);
        check("midrst_readdata", 128'(readdata), 0);
`ifdef DCACHE_STATS_EN
        check("midrst_hit_count", 128'(hit_count), 0);
`endif
        mem_read = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;
        exp_rf.push_back(28'h11); exp_rd.push_back(32'hC0000011);
        access(1, 0, 2'b10, 32'h110, 0, n); check("post_rst_miss_stall", 128'(n), 5);

        repeat (3) @(posedge clk);
        check("rd_queue_drained", 128'(exp_rd.size()), 0);
        check("rf_queue_drained", 128'(exp_rf.size()), 0);
        check("wb_queue_drained", 128'(exp_wb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/data_cache_wb.md
# data_cache_wb

Parametrised direct-mapped, write-back, write-allocate data cache that sits between the pipeline's MEM stage and the line-wide data memory port. It generalises the fixed four-line data cache in three ways:
- set count and line width are parameters;
- byte, half and word accesses are supported;
- flush writes back every dirty line before invalidating.

A single explicit FSM serialises write-back and refill, and a combinational `stall` holds the pipeline.

## Interface
Parameters:
- `NUM_SETS`, 4: number of lines; power of two, ≥2. INDEX_W = log2(NUM_SETS).
- `LINE_BITS`, 128: line width in bits; power of two, ≥64. OFFSET_W = log2(LINE_BITS/8).
- `ADDR_W`, 32: byte address width. LADDR_W = ADDR_W−OFFSET_W; TAG_W = LADDR_W−INDEX_W.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `flush` in 1: one-cycle request for write-back-and-invalidate of the whole cache.
- `mem_read` in 1: load request.
- `mem_write` in 1: store request.
- `access_size` in 2: access size; 00 byte, 01 half, 10 word, 11 treated as word.
- `address` in ADDR_W: byte address.
- `writedata` in 32: store data, right-aligned.
- `readdata` out 32: load data, zero-extended.
- `stall` out 1: pipeline must hold the current request.
- `flush_done` out 1: one-cycle pulse when a flush completes.
- `reqD_mem` out 1: refill request.
- `reqAddrD_mem` out LADDR_W: refill line address.
- `data_from_mem` in LINE_BITS: refill data.
- `read_ready_from_mem` in 1: refill data valid.
- `reqD_cache_write` out 1: write-back request.
- `reqAddrD_write_mem` out LADDR_W: write-back line address, {tag, index}.
- `data_to_mem` out LINE_BITS: write-back data.
- `written_data_ack` in 1: write-back accepted.

## Operation
- Per set: data[LINE_BITS], tag[TAG_W], valid, dirty.
- Address split: offset = address[OFFSET_W-1:0], index = next INDEX_W bits, tag = the rest.
- Low address bits below the access size are ignored (forced aligned).
- Byte k of a line is data[8k+7:8k]. Little-endian: an access at offset o uses bytes o .. o+size−1.
- `mem_write` has priority when both `mem_read` and `mem_write` are high.
- hit = valid[index] && tag[index]==tag. This is combinational in IDLE.

FSM states: IDLE, WRITEBACK, REFILL, FLUSH_SCAN, FLUSH_WB.
- **IDLE, read hit:** `readdata` is driven combinationally the same cycle and `stall`=0.
- **IDLE, write hit:** the selected bytes are merged at the clock edge and dirty is set; `stall`=0.
- **IDLE, miss:**
  - If valid&&dirty: go to WRITEBACK, latching `data_to_mem` = old line and `reqAddrD_write_mem` = {old tag, index}.
  - Otherwise: go to REFILL, latching `reqAddrD_mem` = {tag, index}.
- **WRITEBACK:** `reqD_cache_write` held at 1 until `written_data_ack` is sampled at 1. Then dirty is cleared and the FSM goes to REFILL.
- **REFILL:** `reqD_mem` held at 1 until `read_ready_from_mem` is sampled at 1. Then `data_from_mem`, the tag and valid=1 are installed, dirty=0, and the FSM goes to IDLE.
- **Back in IDLE:** the still-held request now hits. A store merges here (write-allocate).
- **Flush:**
  - A flush pulse seen in any state is latched as pending and taken in IDLE, with priority over an access.
  - FLUSH_SCAN visits sets 0..NUM_SETS−1, one cycle per clean or invalid set.
  - A dirty set goes to FLUSH_WB, using the same handshake as WRITEBACK, then resumes the scan at the next set.
  - After the last set: all valid and dirty bits are cleared, `flush_done`=1 for one cycle, and the FSM returns to IDLE.
- **Stray handshakes:** `written_data_ack` outside WRITEBACK/FLUSH_WB and `read_ready_from_mem` outside REFILL are ignored.

## Timing
- `stall` = (`mem_read`|`mem_write`) && !(state==IDLE && !flush_pending && hit). During a flush, `stall`=1 whenever a request is present.
- Request outputs are registered: they assert the cycle after miss detection and deassert on the edge where the ack is sampled.
- Clean miss, memory responding k cycles after `reqD_mem` rises: `stall` is high for k+2 cycles.
- Dirty miss: adds write-back latency plus 1 cycle.
- `readdata` is 0 whenever no read hit is present in IDLE.
- Reset (asynchronous, any state, including mid-handshake):
  - state=IDLE, all valid/dirty=0, flush_pending=0.
  - `reqD_mem`, `reqD_cache_write`, `flush_done`=0; all address and data outputs=0.
  - Memory must drop any in-flight transaction.

## Configuration
- `DCACHE_STATS_EN` defined: adds outputs `hit_count`, `miss_count` and `wb_count`, each 32 bits.
  - Each is a wrapping counter, reset to 0.
  - Hits count only on first-try IDLE hits.
  - Misses count on IDLE miss detection.
  - Write-backs count on each accepted `written_data_ack`, including during flush.
  - `flush` does not clear the counters.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

## Test plan
- **Cold read miss:** reset, read word 0x100, memory returns line 0x...DDCCBBAA_44332211 after 3 cycles. Required: `reqAddrD_mem`=0x10, `stall` high 5 cycles, `readdata`=0x44332211.
- **Byte/half stores on a hit:** store byte 0xEE to 0x101, then half 0xBEEF to 0x102, then read word 0x100. Required: `readdata`=0xBEEFEE11 and dirty[0]=1.
- **Dirty eviction:** write to 0x100, then read 0x140 (same index, NUM_SETS=4). Required: `reqD_cache_write` with `reqAddrD_write_mem`=0x10 first; after ack, `reqD_mem` with address 0x14.
- **Flush with two dirty sets:** required: exactly two write-back handshakes in index order, then `flush_done` 1 cycle, then all reads miss.
- **Mid-refill reset:** assert `reset` while `reqD_mem`=1. Required: all outputs 0 immediately, and the next read of the same address misses.
- **Stats:** with `DCACHE_STATS_EN`, the sequence above yields the exact hit/miss/wb counts.
